fft_peak_search: RTL and testbench



---
 rtl/fft_peak_search.sv | 181 ++++++++++++++++++
 tb/tb_fft_peak_search.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_search.sv
// Magnitude estimate (alpha-max-beta-min) on a streaming FFT output. Per-frame
// search for the strongest in-window bin, reported with both neighbour magnitudes.
module fft_peak_search #(
   parameter int NPTS_LOG2 = 10,
   parameter int DW        = 27,
   parameter int BIN_LO    = 2,
   parameter int BIN_HI    = 511
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 FFTDOE,
   input  logic [DW-1:0]        FFTDATI,
   input  logic [DW-1:0]        FFTDATQ,
   output logic                 MAGDOE,
   output logic [DW:0]          MAGDAT,
   output logic                 PEAKVLD,
   output logic [NPTS_LOG2-1:0] PEAKBIN,
   output logic [DW:0]          PEAKMAG,
   output logic [DW:0]          PEAKMAGL,
   output logic [DW:0]          PEAKMAGR
);

   typedef enum logic {SEARCH, REPORT} state_t;

   localparam logic [NPTS_LOG2-1:0] LAST_BIN = '1;
   localparam logic [NPTS_LOG2-1:0] LO_BIN   = NPTS_LOG2'(BIN_LO);
   localparam logic [NPTS_LOG2-1:0] HI_BIN   = NPTS_LOG2'(BIN_HI);

   // Sign-extend before negating so the most negative input maps to +2^(DW-1).
   function automatic logic [DW:0] abs_ext(input logic [DW-1:0] x);
      logic [DW:0] s;
      s = {x[DW-1], x};
      return x[DW-1] ? (~s + (DW+1)'(1)) : s;
   endfunction

   logic                 in_v_q, in_v_d, v1_q, v1_d, v2_q, v2_d, magdoe_q, magdoe_d;
   logic [DW-1:0]        in_i_q, in_i_d, in_q_q, in_q_d;
   logic [DW:0]          abs_i_q, abs_i_d, abs_q_q, abs_q_d;
   logic [DW:0]          mx_q, mx_d, mn_q, mn_d, magdat_q, magdat_d;
   logic [NPTS_LOG2-1:0] bin_q, bin_d;

   state_t               state_q, state_d;
   logic                 found_q, found_d, rpend_q, rpend_d;
   logic [NPTS_LOG2-1:0] wk_bin_q, wk_bin_d, pk_bin_q, pk_bin_d;
   logic [DW:0]          prev_mag_q, prev_mag_d;
   logic [DW:0]          wk_mag_q, wk_mag_d, wk_magl_q, wk_magl_d, wk_magr_q, wk_magr_d;
   logic [DW:0]          pk_mag_q, pk_mag_d, pk_magl_q, pk_magl_d, pk_magr_q, pk_magr_d;
   logic                 last_sample, in_win;

   // Input capture, then |I|/|Q|, then max/min, then the sum.
   always_comb begin
      in_v_d   = FFTDOE;
      in_i_d   = FFTDATI;
      in_q_d   = FFTDATQ;
      v1_d     = in_v_q;
      abs_i_d  = abs_ext(in_i_q);
      abs_q_d  = abs_ext(in_q_q);
      v2_d     = v1_q;
      mx_d     = (abs_i_q >= abs_q_q) ? abs_i_q : abs_q_q;
      mn_d     = (abs_i_q >= abs_q_q) ? abs_q_q : abs_i_q;
      magdoe_d = v2_q;
      magdat_d = mx_q + (mn_q >> 1);
      bin_d    = magdoe_q ? bin_q + NPTS_LOG2'(1) : bin_q;
   end

   assign last_sample = magdoe_q && (bin_q == LAST_BIN);
   assign in_win      = (bin_q >= LO_BIN) && (bin_q <= HI_BIN);

   always_comb begin
      state_d = last_sample ? REPORT : SEARCH;
   end

   always_comb begin
      PEAKVLD = (state_q == REPORT);
   end

   // Working peak update; on the last bin the completed result moves to the
   // output registers and the working set is cleared for the next frame.
   always_comb begin
      found_d    = found_q;
      rpend_d    = rpend_q;
      prev_mag_d = prev_mag_q;
      wk_bin_d   = wk_bin_q;
      wk_mag_d   = wk_mag_q;
      wk_magl_d  = wk_magl_q;
      wk_magr_d  = wk_magr_q;
      pk_bin_d   = pk_bin_q;
      pk_mag_d   = pk_mag_q;
      pk_magl_d  = pk_magl_q;
      pk_magr_d  = pk_magr_q;
      if (magdoe_q) begin
         prev_mag_d = magdat_q;
         if (rpend_q) begin
            wk_magr_d = magdat_q;
            rpend_d   = 1'b0;
         end
         if (in_win && (!found_q || (magdat_q > wk_mag_q))) begin
            found_d   = 1'b1;
            wk_bin_d  = bin_q;
            wk_mag_d  = magdat_q;
            wk_magl_d = (bin_q == '0) ? '0 : prev_mag_q;
            wk_magr_d = '0;
            rpend_d   = !last_sample;
         end
         if (last_sample) begin
            pk_bin_d  = wk_bin_d;
            pk_mag_d  = wk_mag_d;
            pk_magl_d = wk_magl_d;
            pk_magr_d = wk_magr_d;
            found_d   = 1'b0;
            rpend_d   = 1'b0;
            wk_bin_d  = '0;
            wk_mag_d  = '0;
            wk_magl_d = '0;
            wk_magr_d = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         in_v_q     <= 1'b0;
         in_i_q     <= '0;
         in_q_q     <= '0;
         v1_q       <= 1'b0;
         abs_i_q    <= '0;
         abs_q_q    <= '0;
         v2_q       <= 1'b0;
         mx_q       <= '0;
         mn_q       <= '0;
         magdoe_q   <= 1'b0;
         magdat_q   <= '0;
         bin_q      <= '0;
         state_q    <= SEARCH;
         found_q    <= 1'b0;
         rpend_q    <= 1'b0;
         prev_mag_q <= '0;
         wk_bin_q   <= '0;
         wk_mag_q   <= '0;
         wk_magl_q  <= '0;
         wk_magr_q  <= '0;
         pk_bin_q   <= '0;
         pk_mag_q   <= '0;
         pk_magl_q  <= '0;
         pk_magr_q  <= '0;
      end else begin
         in_v_q     <= in_v_d;
         in_i_q     <= in_i_d;
         in_q_q     <= in_q_d;
         v1_q       <= v1_d;
         abs_i_q    <= abs_i_d;
         abs_q_q    <= abs_q_d;
         v2_q       <= v2_d;
         mx_q       <= mx_d;
         mn_q       <= mn_d;
         magdoe_q   <= magdoe_d;
         magdat_q   <= magdat_d;
         bin_q      <= bin_d;
         state_q    <= state_d;
         found_q    <= found_d;
         rpend_q    <= rpend_d;
         prev_mag_q <= prev_mag_d;
         wk_bin_q   <= wk_bin_d;
         wk_mag_q   <= wk_mag_d;
         wk_magl_q  <= wk_magl_d;
         wk_magr_q  <= wk_magr_d;
         pk_bin_q   <= pk_bin_d;
         pk_mag_q   <= pk_mag_d;
         pk_magl_q  <= pk_magl_d;
         pk_magr_q  <= pk_magr_d;
      end
   end

   assign MAGDOE   = magdoe_q;
   assign MAGDAT   = magdat_q;
   assign PEAKBIN  = pk_bin_q;
   assign PEAKMAG  = pk_mag_q;
   assign PEAKMAGL = pk_magl_q;
   assign PEAKMAGR = pk_magr_q;

endmodule

// File: tb/tb_fft_peak_search.sv
// Directed bench for fft_peak_search: per-frame vector table, per-sample magnitude
// scoreboard and valid-alignment check, plus back-to-back and mid-frame reset sequences.
module tb_fft_peak_search;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        FFTDOE = 1'b0;
   logic [26:0] FFTDATI = '0;
   logic [26:0] FFTDATQ = '0;
   logic        MAGDOE, PEAKVLD;
   logic [27:0] MAGDAT, PEAKMAG, PEAKMAGL, PEAKMAGR;
   logic [9:0]  PEAKBIN;

   fft_peak_search dut (
      .CLK(CLK), .RST(RST), .FFTDOE(FFTDOE), .FFTDATI(FFTDATI), .FFTDATQ(FFTDATQ),
      .MAGDOE(MAGDOE), .MAGDAT(MAGDAT), .PEAKVLD(PEAKVLD), .PEAKBIN(PEAKBIN),
      .PEAKMAG(PEAKMAG), .PEAKMAGL(PEAKMAGL), .PEAKMAGR(PEAKMAGR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int vec; int bin; int i; int q;
   } tone_t;
   typedef struct {
      bit gap; int e_bin; longint e_mag; longint e_l; longint e_r;
   } vec_t;
   typedef struct {
      int bin; longint mag; longint l; longint r; int cyc;
   } rep_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   bit          mon_en = 1'b0;
   logic [3:0]  doe_hist = '0;
   logic [27:0] exp_q[$];
   rep_t        rep_q[$];
   int          fi[0:2047];
   int          fq[0:2047];
   tone_t       tones[$];
   vec_t        vt[7];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint mag_model(input logic [26:0] i, input logic [26:0] q);
      longint ai, aq, mx, mn;
      ai = longint'($signed(i));
      aq = longint'($signed(q));
      if (ai < 0) ai = -ai;
      if (aq < 0) aq = -aq;
      mx = (ai > aq) ? ai : aq;
      mn = (ai > aq) ? aq : ai;
      return mx + (mn >>> 1);
   endfunction

   // Magnitude scoreboard, 4-cycle valid alignment and report capture.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (MAGDOE) begin
            if (exp_q.size() == 0) chk("magdat_unexpected", 1, 0);
            else chk("magdat", longint'(MAGDAT), longint'(exp_q.pop_front()));
         end
         chk("magdoe_align", longint'(MAGDOE), longint'(doe_hist[3]));
         if (PEAKVLD)
            rep_q.push_back('{int'(PEAKBIN), longint'(PEAKMAG), longint'(PEAKMAGL),
                              longint'(PEAKMAGR), cyc});
      end
      doe_hist = {doe_hist[2:0], FFTDOE & ~RST};
      if (RST) begin
         doe_hist = '0;
         exp_q.delete();
      end else if (FFTDOE) begin
         exp_q.push_back(28'(mag_model(FFTDATI, FFTDATQ)));
      end
   end

   task automatic idle_cycle();
      @(posedge CLK); #1;
      FFTDOE = 1'b0; FFTDATI = '0; FFTDATQ = '0;
   endtask

   task automatic drive_bins(input int nbins, input bit gap);
      for (int b = 0; b < nbins; b++) begin
         if (gap) repeat ($urandom_range(0, 2)) idle_cycle();
         @(posedge CLK); #1;
         FFTDOE = 1'b1; FFTDATI = 27'(fi[b]); FFTDATQ = 27'(fq[b]);
         last_cyc = cyc;
      end
      idle_cycle();
   endtask

   task automatic clear_frame();
      for (int k = 0; k < 2048; k++) begin
         fi[k] = 0; fq[k] = 0;
      end
   endtask

   task automatic wait_reports(input int n);
      for (int k = 0; k < 3000 && rep_q.size() < n; k++) @(posedge CLK);
      repeat (8) @(posedge CLK);
      chk("report_count", rep_q.size(), n);
   endtask

   task automatic pulse_reset();
      @(posedge CLK); #1;
      RST = 1'b1; FFTDOE = 1'b0; FFTDATI = '0; FFTDATQ = '0;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   initial begin
      // vec 0 single tone, 1 tie/window, 2 full scale, 3 gapped tone,
      // 4 all-zero frame, 5 peak at BIN_HI, 6 peak at BIN_LO
      tones = '{
         '{0, 100, 1000, 0}, '{0, 99, 0, -400}, '{0, 101, 300, 300},
         '{1, 0, 5000, 0}, '{1, 1, 5000, 0}, '{1, 600, 5000, 0},
         '{1, 40, 3000, -3000}, '{1, 41, 3000, -3000},
         '{2, 200, -67108864, -67108864},
         '{3, 100, 1000, 0}, '{3, 99, 0, -400}, '{3, 101, 300, 300},
         '{5, 510, 10, 0}, '{5, 511, 100, 0}, '{5, 512, 900, 0},
         '{6, 1, 77, 0}, '{6, 2, 50, 0}
      };
      vt[0] = '{1'b0, 100, 1000, 400, 450};
      vt[1] = '{1'b0, 40, 4500, 0, 4500};
      vt[2] = '{1'b0, 200, 100663296, 0, 0};
      vt[3] = '{1'b1, 100, 1000, 400, 450};
      vt[4] = '{1'b0, 2, 0, 0, 0};
      vt[5] = '{1'b0, 511, 100, 10, 900};
      vt[6] = '{1'b0, 2, 50, 77, 0};

      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      mon_en = 1'b1;
      @(negedge CLK);
      chk("rst_magdoe", MAGDOE, 0);
      chk("rst_magdat", MAGDAT, 0);
      chk("rst_peakvld", PEAKVLD, 0);
      chk("rst_peakbin", PEAKBIN, 0);
      chk("rst_peakmag", PEAKMAG, 0);
      chk("rst_peakmagl", PEAKMAGL, 0);
      chk("rst_peakmagr", PEAKMAGR, 0);

      for (int v = 0; v < 7; v++) begin
         clear_frame();
         foreach (tones[t]) if (tones[t].vec == v) begin
            fi[tones[t].bin] = tones[t].i;
            fq[tones[t].bin] = tones[t].q;
         end
         rep_q.delete();
         drive_bins(1024, vt[v].gap);
         wait_reports(1);
         if (rep_q.size() > 0) begin
            chk($sformatf("v%0d_peakbin", v), rep_q[0].bin, vt[v].e_bin);
            chk($sformatf("v%0d_peakmag", v), rep_q[0].mag, vt[v].e_mag);
            chk($sformatf("v%0d_peakmagl", v), rep_q[0].l, vt[v].e_l);
            chk($sformatf("v%0d_peakmagr", v), rep_q[0].r, vt[v].e_r);
            chk($sformatf("v%0d_latency", v), rep_q[0].cyc - last_cyc, 5);
         end
         @(negedge CLK);
         chk($sformatf("v%0d_hold_bin", v), PEAKBIN, vt[v].e_bin);
         chk($sformatf("v%0d_hold_mag", v), PEAKMAG, vt[v].e_mag);
      end

      // Back-to-back frames: no idle between bin 1023 of A and bin 0 of B.
      clear_frame();
      fi[10] = 700; fi[9] = 20; fi[11] = 30;
      fi[1024] = 9999; fi[1024 + 300] = -900;
      rep_q.delete();
      drive_bins(2048, 1'b0);
      wait_reports(2);
      if (rep_q.size() >= 2) begin
         chk("b2b_a_bin", rep_q[0].bin, 10);
         chk("b2b_a_mag", rep_q[0].mag, 700);
         chk("b2b_a_magl", rep_q[0].l, 20);
         chk("b2b_a_magr", rep_q[0].r, 30);
         chk("b2b_b_bin", rep_q[1].bin, 300);
         chk("b2b_b_mag", rep_q[1].mag, 900);
         chk("b2b_spacing", rep_q[1].cyc - rep_q[0].cyc, 1024);
      end

      // Reset after bin 500 of a frame peaking at bin 50.
      clear_frame();
      fi[50] = 2000;
      rep_q.delete();
      drive_bins(501, 1'b0);
      pulse_reset();
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("abort_no_report", rep_q.size(), 0);
      chk("abort_magdoe", MAGDOE, 0);
      chk("abort_peakbin", PEAKBIN, 0);
      chk("abort_peakmag", PEAKMAG, 0);
      chk("abort_peakmagl", PEAKMAGL, 0);
      chk("abort_peakmagr", PEAKMAGR, 0);
      clear_frame();
      fi[6] = 5; fi[7] = 123; fi[8] = 9;
      drive_bins(1024, 1'b0);
      wait_reports(1);
      if (rep_q.size() > 0) begin
         chk("post_rst_bin", rep_q[0].bin, 7);
         chk("post_rst_mag", rep_q[0].mag, 123);
         chk("post_rst_magl", rep_q[0].l, 5);
         chk("post_rst_magr", rep_q[0].r, 9);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
